// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - ALU function-code decoder with single-entry output register and mul/div occupancy sequencer
module alu_ctrl_seq #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int FN_W     = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      opcode,
    input  logic [5:0]      rtype_fncode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FN_W-1:0] fncode,
    output logic            illegal,
    output logic            md_start,
    output logic            md_busy,
    output logic            md_done
);

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] OPCODE_ADDIU = 6'h09;
    localparam logic [5:0] OPCODE_SLTI  = 6'h0A;
    localparam logic [5:0] OPCODE_SLTIU = 6'h0B;
    localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
    localparam logic [5:0] OPCODE_ORI   = 6'h0D;
    localparam logic [5:0] OPCODE_XORI  = 6'h0E;
    localparam logic [5:0] OPCODE_LB    = 6'h20;
    localparam logic [5:0] OPCODE_LH    = 6'h21;
    localparam logic [5:0] OPCODE_LWL   = 6'h22;
    localparam logic [5:0] OPCODE_LW    = 6'h23;
    localparam logic [5:0] OPCODE_LBU   = 6'h24;
    localparam logic [5:0] OPCODE_LHU   = 6'h25;
    localparam logic [5:0] OPCODE_LWR   = 6'h26;
    localparam logic [5:0] OPCODE_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;
    localparam logic [5:0] FUNCT_BAD   = 6'h3F;

    localparam logic [5:0] MULT_CNT = 6'(MULT_LAT);
    localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [5:0] cnt;
    logic [5:0] dec_fn;
    logic       dec_ill;
    logic       is_rtype;
    logic       is_mult;
    logic       is_div;
    logic       is_hilo;
    logic       hazard;
    logic       accept;
    logic       md_accept;
    logic [5:0] md_lat;

    always_comb begin
        dec_fn  = FUNCT_BAD;
        dec_ill = 1'b1;
        case (opcode)
            OPCODE_ADDIU, OPCODE_SW, OPCODE_LW, OPCODE_LB, OPCODE_LBU,
            OPCODE_LH, OPCODE_LHU, OPCODE_LWL, OPCODE_LWR: begin
                dec_fn  = FUNCT_ADDU;
                dec_ill = 1'b0;
            end
            OPCODE_ANDI:  begin dec_fn = FUNCT_AND;    dec_ill = 1'b0; end
            OPCODE_ORI:   begin dec_fn = FUNCT_OR;     dec_ill = 1'b0; end
            OPCODE_XORI:  begin dec_fn = FUNCT_XOR;    dec_ill = 1'b0; end
            OPCODE_SLTI:  begin dec_fn = FUNCT_SLT;    dec_ill = 1'b0; end
            OPCODE_SLTIU: begin dec_fn = FUNCT_SLTU;   dec_ill = 1'b0; end
            OPCODE_RTYPE: begin dec_fn = rtype_fncode; dec_ill = 1'b0; end
            default: ;
        endcase
    end

    assign is_rtype  = (opcode == OPCODE_RTYPE);
    assign is_mult   = is_rtype && (rtype_fncode == FUNCT_MULT || rtype_fncode == FUNCT_MULTU);
    assign is_div    = is_rtype && (rtype_fncode == FUNCT_DIV  || rtype_fncode == FUNCT_DIVU);
    assign is_hilo   = is_rtype && (rtype_fncode == FUNCT_MFHI || rtype_fncode == FUNCT_MTHI ||
                                    rtype_fncode == FUNCT_MFLO || rtype_fncode == FUNCT_MTLO);
    // The done cycle releases the hazard so a waiting HI/LO or mul/div op issues with no bubble
    assign hazard    = md_busy && !md_done && (is_mult || is_div || is_hilo);
    assign in_ready  = (!out_valid || out_ready) && !hazard;
    assign accept    = in_valid && in_ready;
    assign md_accept = accept && (is_mult || is_div);
    assign md_lat    = is_mult ? MULT_CNT : DIV_CNT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            fncode    <= '0;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            fncode    <= FN_W'(dec_fn);
            illegal   <= dec_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            md_start <= 1'b0;
            md_busy  <= 1'b0;
            md_done  <= 1'b0;
        end else if (md_accept) begin
            state    <= BUSY;
            cnt      <= md_lat;
            md_start <= 1'b1;
            md_busy  <= 1'b1;
            md_done  <= (md_lat == 6'd1);
        end else begin
            md_start <= 1'b0;
            case (state)
                IDLE: begin
                    md_busy <= 1'b0;
                    md_done <= 1'b0;
                end
                BUSY: begin
                    if (cnt > 6'd1) begin
                        cnt     <= cnt - 6'd1;
                        md_done <= (cnt == 6'd2);
                    end else begin
                        state   <= IDLE;
                        cnt     <= 6'd0;
                        md_busy <= 1'b0;
                        md_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - self-checking bench for alu_ctrl_seq, two parameter sets sharing one stimulus
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       out_ready;
    logic [5:0] opcode;
    logic [5:0] rtype_fncode;

    logic       rdy0, ov0, ill0, st0, bz0, dn0;
    logic [5:0] fn0;
    logic       rdy1, ov1, ill1, st1, bz1, dn1;
    logic [7:0] fn1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(.MULT_LAT(4), .DIV_LAT(32), .FN_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy0),
        .opcode(opcode), .rtype_fncode(rtype_fncode), .out_valid(ov0),
        .out_ready(out_ready), .fncode(fn0), .illegal(ill0),
        .md_start(st0), .md_busy(bz0), .md_done(dn0)
    );

    alu_ctrl_seq #(.MULT_LAT(1), .DIV_LAT(32), .FN_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy1),
        .opcode(opcode), .rtype_fncode(rtype_fncode), .out_valid(ov1),
        .out_ready(out_ready), .fncode(fn1), .illegal(ill1),
        .md_start(st1), .md_busy(bz1), .md_done(dn1)
    );

    // Reference model: remaining occupancy in cycles plus the pending output slot
    int         lat_mult[2] = '{4, 1};
    int         lat_div[2]  = '{32, 32};
    int         m_left[2];
    bit         m_start[2];
    bit         m_ov[2];
    logic [5:0] m_fn[2];
    bit         m_ill[2];
    bit         s_ready[2], s_busy[2], s_done[2], s_start[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [6:0] ref_dec(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h09, 6'h2B, 6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h22, 6'h26: return {1'b0, 6'h21};
            6'h0C: return {1'b0, 6'h24};
            6'h0D: return {1'b0, 6'h25};
            6'h0E: return {1'b0, 6'h26};
            6'h0A: return {1'b0, 6'h2A};
            6'h0B: return {1'b0, 6'h2B};
            6'h00: return {1'b0, fn};
            default: return {1'b1, 6'h3F};
        endcase
    endfunction

    function automatic bit ref_md(input logic [5:0] op, input logic [5:0] fn);
        return op == 6'h00 && fn >= 6'h18 && fn <= 6'h1B;
    endfunction

    function automatic bit ref_hz(input logic [5:0] op, input logic [5:0] fn);
        return ref_md(op, fn) || (op == 6'h00 && fn >= 6'h10 && fn <= 6'h13);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_start[k] = 0; m_ov[k] = 0; m_fn[k] = 6'h00; m_ill[k] = 0;
        end
    endtask

    task automatic cycle();
        bit e_ready[2];
        logic [31:0] a_rdy, a_ov, a_fn, a_ill, a_st, a_bz, a_dn;
        @(negedge clk);
        if (!reset_n) m_reset();
        for (int k = 0; k < 2; k++) begin
            bit e_busy, e_done;
            e_busy = m_left[k] > 0;
            e_done = m_left[k] == 1;
            e_ready[k] = (!m_ov[k] || out_ready) && !(e_busy && !e_done && ref_hz(opcode, rtype_fncode));
            a_rdy = k ? 32'(rdy1) : 32'(rdy0);
            a_ov  = k ? 32'(ov1)  : 32'(ov0);
            a_fn  = k ? 32'(fn1)  : 32'(fn0);
            a_ill = k ? 32'(ill1) : 32'(ill0);
            a_st  = k ? 32'(st1)  : 32'(st0);
            a_bz  = k ? 32'(bz1)  : 32'(bz0);
            a_dn  = k ? 32'(dn1)  : 32'(dn0);
            chk($sformatf("in_ready[%0d]", k), a_rdy, 32'(e_ready[k]));
            chk($sformatf("out_valid[%0d]", k), a_ov, 32'(m_ov[k]));
            if (m_ov[k]) begin
                chk($sformatf("fncode[%0d]", k), a_fn, 32'(m_fn[k]));
                chk($sformatf("illegal[%0d]", k), a_ill, 32'(m_ill[k]));
            end
            chk($sformatf("md_start[%0d]", k), a_st, 32'(m_start[k]));
            chk($sformatf("md_busy[%0d]", k), a_bz, 32'(e_busy));
            chk($sformatf("md_done[%0d]", k), a_dn, 32'(e_done));
            s_ready[k] = a_rdy[0]; s_busy[k] = a_bz[0]; s_done[k] = a_dn[0]; s_start[k] = a_st[0];
        end
        @(posedge clk);
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                bit acc;
                acc = in_valid && e_ready[k];
                if (acc) begin
                    m_ov[k] = 1;
                    {m_ill[k], m_fn[k]} = ref_dec(opcode, rtype_fncode);
                end else if (out_ready) begin
                    m_ov[k] = 0;
                end
                if (acc && ref_md(opcode, rtype_fncode)) begin
                    m_left[k]  = (rtype_fncode <= 6'h19) ? lat_mult[k] : lat_div[k];
                    m_start[k] = 1;
                end else begin
                    m_left[k]  = (m_left[k] > 0) ? m_left[k] - 1 : 0;
                    m_start[k] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [5:0] op, input logic [5:0] fn);
        in_valid = v; opcode = op; rtype_fncode = fn;
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] efn;
        logic       eill;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int stalls, busy_cnt;
        bit got;
        vecs[0]  = '{6'h09, 6'h00, 6'h21, 1'b0};
        vecs[1]  = '{6'h2B, 6'h00, 6'h21, 1'b0};
        vecs[2]  = '{6'h23, 6'h00, 6'h21, 1'b0};
        vecs[3]  = '{6'h20, 6'h00, 6'h21, 1'b0};
        vecs[4]  = '{6'h24, 6'h00, 6'h21, 1'b0};
        vecs[5]  = '{6'h21, 6'h00, 6'h21, 1'b0};
        vecs[6]  = '{6'h25, 6'h00, 6'h21, 1'b0};
        vecs[7]  = '{6'h22, 6'h00, 6'h21, 1'b0};
        vecs[8]  = '{6'h26, 6'h00, 6'h21, 1'b0};
        vecs[9]  = '{6'h0C, 6'h00, 6'h24, 1'b0};
        vecs[10] = '{6'h0D, 6'h00, 6'h25, 1'b0};
        vecs[11] = '{6'h0E, 6'h00, 6'h26, 1'b0};
        vecs[12] = '{6'h0A, 6'h00, 6'h2A, 1'b0};
        vecs[13] = '{6'h0B, 6'h00, 6'h2B, 1'b0};
        vecs[14] = '{6'h00, 6'h23, 6'h23, 1'b0};
        vecs[15] = '{6'h3E, 6'h18, 6'h3F, 1'b1};
        vecs[16] = '{6'h02, 6'h1A, 6'h3F, 1'b1};
        vecs[17] = '{6'h00, 6'h2A, 6'h2A, 1'b0};

        reset_n = 1'b0; out_ready = 1'b1;
        drive(0, 6'h00, 6'h00);
        m_reset();
        #2;
        chk("reset out_valid", 32'(ov0), 0);
        chk("reset fncode", 32'(fn1), 0);
        chk("reset md_busy", 32'(bz0), 0);
        repeat (2) cycle();
        reset_n = 1'b1;

        // Decode table, one accept per cycle
        for (int i = 0; i < 18; i++) begin
            drive(1, vecs[i].op, vecs[i].fn);
            cycle();
            chk($sformatf("vec%0d fncode", i), 32'(fn0), 32'(vecs[i].efn));
            chk($sformatf("vec%0d fncode_w8", i), 32'(fn1), 32'(vecs[i].efn));
            chk($sformatf("vec%0d illegal", i), 32'(ill0), 32'(vecs[i].eill));
            chk($sformatf("vec%0d out_valid", i), 32'(ov0), 1);
        end
        drive(0, 6'h00, 6'h00);
        cycle();
        chk("illegal no md_start", 32'(s_start[0] | s_start[1]), 0);

        // ANDI result held under backpressure, ORI waits then lands
        drive(1, 6'h0C, 6'h00);
        cycle();
        drive(1, 6'h0D, 6'h00);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp fncode held", 32'(fn0), 32'h24);
            chk("bp in_ready", 32'(s_ready[0]), 0);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp second result", 32'(fn0), 32'h25);
        drive(0, 6'h00, 6'h00);
        cycle();

        // MULT then ADDIU issues under md_busy
        drive(1, 6'h00, 6'h18);
        cycle();
        drive(1, 6'h09, 6'h00);
        cycle();
        chk("addiu accepted", 32'(s_ready[0]), 1);
        chk("addiu during busy", 32'(s_busy[0]), 1);
        chk("addiu fncode", 32'(fn0), 32'h21);
        drive(0, 6'h00, 6'h00);
        repeat (5) cycle();

        // DIV then MFLO: stalled until the done cycle
        drive(1, 6'h00, 6'h1A);
        cycle();
        drive(1, 6'h00, 6'h12);
        stalls = 0; busy_cnt = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle();
            busy_cnt += s_busy[0];
            if (s_ready[0]) begin
                got = 1;
                chk("mflo in done cycle", 32'(s_done[0]), 1);
            end else stalls++;
        end
        chk("mflo accepted", 32'(got), 1);
        chk("mflo stall cycles", 32'(stalls), 31);
        chk("div busy cycles", 32'(busy_cnt), 32);
        chk("mflo fncode", 32'(fn0), 32'h12);
        drive(0, 6'h00, 6'h00);
        cycle();
        chk("div busy ends", 32'(s_busy[0] | s_busy[1]), 0);

        // Reset in the 10th busy cycle of a DIV, result still pending
        drive(1, 6'h00, 6'h1B);
        cycle();
        drive(0, 6'h00, 6'h00);
        out_ready = 1'b0;
        repeat (9) cycle();
        chk("pre-reset busy0", 32'(bz0), 1);
        chk("pre-reset busy1", 32'(bz1), 1);
        chk("pre-reset out_valid", 32'(ov0), 1);
        reset_n = 1'b0;
        #1;
        chk("async busy0", 32'(bz0), 0);
        chk("async busy1", 32'(bz1), 0);
        chk("async out_valid0", 32'(ov0), 0);
        chk("async out_valid1", 32'(ov1), 0);
        chk("async no done", 32'(dn0 | dn1), 0);
        out_ready = 1'b1;
        repeat (2) cycle();
        reset_n = 1'b1;
        drive(1, 6'h0D, 6'h00);
        cycle();
        chk("first accept after reset", 32'(ov0), 1);
        chk("first accept fncode", 32'(fn0), 32'h25);

        // MULT with latency 1: start and done coincide
        drive(1, 6'h00, 6'h19);
        cycle();
        drive(0, 6'h00, 6'h00);
        cycle();
        chk("lat1 start", 32'(s_start[1]), 1);
        chk("lat1 done", 32'(s_done[1]), 1);
        cycle();
        chk("lat1 idle", 32'(s_busy[1]), 0);
        repeat (4) cycle();

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [5:0] ops[10];
            logic [5:0] fns[10];
            ops = '{6'h00, 6'h00, 6'h00, 6'h09, 6'h23, 6'h0C, 6'h0D, 6'h0B, 6'h3E, 6'h01};
            fns = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13, 6'h21, 6'h2A};
            in_valid     = ($urandom_range(3) != 0);
            out_ready    = ($urandom_range(3) != 0);
            opcode       = ops[$urandom_range(9)];
            rtype_fncode = fns[$urandom_range(9)];
            cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
